sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, byte-address width of requester ports.
REQ-002 Parameter: DATA_W, default 32, data width (fixed 32; 4 byte strobes).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_req  in  1  instruction-fetch read request, held until inst_addr_ok.
REQ-006 inst_addr  in  ADDR_W  fetch byte address.
REQ-007 inst_addr_ok  out  1  fetch request accepted this cycle.
REQ-008 inst_data_ok  out  1  fetch response valid.
REQ-009 inst_rdata  out  DATA_W  fetch response word.
REQ-010 data_req  in  1  load/store request, held until data_addr_ok.
REQ-011 data_wr  in  1  1 = store, 0 = load.
REQ-012 data_wstrb  in  4  store byte enables.
REQ-013 data_addr  in  ADDR_W  load/store byte address.
REQ-014 data_wdata  in  DATA_W  store data.
REQ-015 data_addr_ok  out  1  load/store accepted this cycle.
REQ-016 data_data_ok  out  1  load/store completion (store also completes).
REQ-017 data_rdata  out  DATA_W  load response word.
REQ-018 sram_en  out  1  SRAM access enable.
REQ-019 sram_wen  out  4  SRAM byte write enables.
REQ-020 sram_addr  out  ADDR_W  SRAM word index.
REQ-021 sram_wdata  out  DATA_W  SRAM write data.
REQ-022 sram_rdata  in  DATA_W  SRAM combinational read data.

Function
REQ-023 At most one request is granted per cycle; grant is combinational from the req inputs and the arbitration state.
REQ-024 Granted request drives sram_en=1 and sram_addr={2'b0, addr[ADDR_W-1:2]}; byte offset is ignored.
REQ-025 sram_wen=data_wstrb only for a granted store; 0 otherwise; sram_wdata=data_wdata when data is granted, else 0.
REQ-026 No grant -> sram_en=0, sram_wen=0, sram_addr=0.
REQ-027 Response latency is exactly 1 cycle: accepted at edge N, *_data_ok=1 for exactly cycle N+1 with *_rdata=sram_rdata registered at edge N.
REQ-028 Back-to-back acceptance is allowed every cycle; a response and a new acceptance coexist in the same cycle.
REQ-029 FSM states IDLE, RESP_I, RESP_D record the owner of the response in flight; next state = RESP_I/RESP_D on fetch/data grant, else IDLE.
REQ-030 *_rdata holds its last value when *_data_ok=0; data_rdata after a store is don't-care but *_data_ok still pulses.
REQ-031 Default arbitration: data has fixed priority over fetch when both request in the same cycle.
REQ-032 A lone requester is granted in the cycle it asserts req (zero wait).

Reset
REQ-033 reset=1 at a rising edge forces state IDLE, both *_data_ok=0, both *_rdata=0, last-grant=INST.
REQ-034 While reset=1, *_addr_ok=0 and sram_en=0 regardless of req; a response in flight at reset is discarded.

Configuration
REQ-035 Macro SRAM_ARB_RR_EN defined: on simultaneous requests, grant the requester not granted on the previous grant (last-grant register, initial INST, so first conflict goes to data).
REQ-036 Macro undefined: fixed data priority per REQ-031; last-grant register not implemented.

Structure
REQ-037 Shared package holds FSM state encoding (IDLE/RESP_I/RESP_D), the requester ID enum (INST/DATA), and the WSTRB_W=4 constant.
REQ-038 One sub-module: sram_arb_pick (two-input grant logic, fixed or round-robin per macro); the SRAM itself is instantiated outside.

Verification
REQ-039 Fetch only: inst_req, addr 0x0000_0010 -> inst_addr_ok same cycle, sram_addr=0x4, inst_data_ok next cycle with memory word 4.
REQ-040 Store then load: store wstrb=4'b0011, data 0xAABB_CCDD to 0x20 (word 0xDEAD_BEEF) -> sram_wen=4'b0011; subsequent load returns 0xDEAD_CCDD.
REQ-041 Conflict, macro undefined: both req held 4 cycles -> data granted all 4 cycles, fetch starved, data_data_ok 4 consecutive cycles.
REQ-042 Conflict, SRAM_ARB_RR_EN: both req held 4 cycles -> grants D,I,D,I; responses alternate one cycle later.
REQ-043 Reset mid-operation: assert reset in cycle after acceptance -> no data_ok pulse, all outputs 0, first post-reset conflict grants data.
REQ-044 Idle: no req for 10 cycles -> sram_en=0, sram_wen=0, no *_data_ok, *_rdata unchanged.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the sram_arbiter block.
// Round-robin arbitration is selected with the SRAM_ARB_RR_EN macro.
package sram_arbiter_pkg;

  localparam int WSTRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESP_I = 2'd1,
    ST_RESP_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_INST = 1'b0,
    REQ_DATA = 1'b1
  } req_id_t;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-input grant logic: fixed data priority by default, round-robin on
// conflicts when SRAM_ARB_RR_EN is defined.
module sram_arb_pick
  import sram_arbiter_pkg::*;
(
`ifdef SRAM_ARB_RR_EN
  input  logic clk,
  input  logic reset,
`endif
  input  logic i_inst_req,
  input  logic i_data_req,
  output logic o_grant_inst,
  output logic o_grant_data
);

`ifdef SRAM_ARB_RR_EN
  req_id_t r_last_grant;

  // Remember the most recent winner so the next conflict goes to the other side.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= REQ_INST;
    end else if (o_grant_inst) begin
      r_last_grant <= REQ_INST;
    end else if (o_grant_data) begin
      r_last_grant <= REQ_DATA;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  // Alternate on conflicts; a lone requester wins immediately.
  always_comb begin
    o_grant_inst = 1'b0;
    o_grant_data = 1'b0;
    if (i_inst_req && i_data_req) begin
      if (r_last_grant == REQ_INST) begin
        o_grant_data = 1'b1;
      end else begin
        o_grant_inst = 1'b1;
      end
    end else begin
      o_grant_inst = i_inst_req;
      o_grant_data = i_data_req;
    end
  end
`else
  // Data always wins a conflict; a lone requester wins immediately.
  always_comb begin
    o_grant_inst = 1'b0;
    o_grant_data = 1'b0;
    if (i_data_req) begin
      o_grant_data = 1'b1;
    end else begin
      o_grant_inst = i_inst_req;
    end
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto one single-cycle SRAM.
// Define SRAM_ARB_RR_EN for round-robin conflict resolution (default: data priority).
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inst_req,
  input  logic [ADDR_W-1:0]  inst_addr,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,
  output logic [DATA_W-1:0]  inst_rdata,
  input  logic               data_req,
  input  logic               data_wr,
  input  logic [WSTRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [DATA_W-1:0]  data_wdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,
  output logic [DATA_W-1:0]  data_rdata,
  output logic               sram_en,
  output logic [WSTRB_W-1:0] sram_wen,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  input  logic [DATA_W-1:0]  sram_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              w_inst_req;
  logic              w_data_req;
  logic              w_grant_inst;
  logic              w_grant_data;
  logic              w_inst_resp;
  logic              w_data_resp;
  logic [DATA_W-1:0] r_inst_rdata;
  logic [DATA_W-1:0] r_data_rdata;
  logic              w_unused_addr_bits;

  // Byte offsets never reach the word-addressed SRAM.
  assign w_unused_addr_bits = ^{inst_addr[1:0], data_addr[1:0]};

  assign w_inst_req = inst_req & ~reset;
  assign w_data_req = data_req & ~reset;

  sram_arb_pick u_pick (
`ifdef SRAM_ARB_RR_EN
    .clk          (clk),
    .reset        (reset),
`endif
    .i_inst_req   (w_inst_req),
    .i_data_req   (w_data_req),
    .o_grant_inst (w_grant_inst),
    .o_grant_data (w_grant_data)
  );

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;

  // Steer the granted requester onto the SRAM port.
  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = {WSTRB_W{1'b0}};
    sram_addr  = {ADDR_W{1'b0}};
    sram_wdata = {DATA_W{1'b0}};
    if (w_grant_data) begin
      sram_en    = 1'b1;
      sram_wen   = data_wr ? data_wstrb : {WSTRB_W{1'b0}};
      sram_addr  = {2'b00, data_addr[ADDR_W-1:2]};
      sram_wdata = data_wdata;
    end else if (w_grant_inst) begin
      sram_en   = 1'b1;
      sram_addr = {2'b00, inst_addr[ADDR_W-1:2]};
    end else begin
      sram_en = 1'b0;
    end
  end

  // Next state records who owns the response due next cycle.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_inst_resp = 1'b0;
    w_data_resp = 1'b0;
    if (w_grant_data) begin
      w_state_nxt = ST_RESP_D;
    end else if (w_grant_inst) begin
      w_state_nxt = ST_RESP_I;
    end else begin
      w_state_nxt = ST_IDLE;
    end
    case (r_state)
      ST_RESP_I: w_inst_resp = 1'b1;
      ST_RESP_D: w_data_resp = 1'b1;
      ST_IDLE:   w_inst_resp = 1'b0;
      default:   w_data_resp = 1'b0;
    endcase
  end

  // State and captured read words; rdata holds between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_inst_rdata <= {DATA_W{1'b0}};
      r_data_rdata <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_inst) begin
        r_inst_rdata <= sram_rdata;
      end
      if (w_grant_data) begin
        r_data_rdata <= sram_rdata;
      end
    end
  end

  // A response still in flight when reset rises is dropped immediately.
  assign inst_data_ok = w_inst_resp & ~reset;
  assign data_data_ok = w_data_resp & ~reset;
  assign inst_rdata   = reset ? {DATA_W{1'b0}} : r_inst_rdata;
  assign data_rdata   = reset ? {DATA_W{1'b0}} : r_data_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a rule-level model predicts grants and
// responses; a separate monitor compares responses as the DUT presents them.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, data_wr;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    bit          is_data;
    bit          is_store;
    logic [31:0] rdata;
    int          due;
  } resp_t;
  resp_t exp_q[$];

  logic [31:0] mem   [0:255];
  logic [31:0] m_mem [0:255];
  bit          m_last_data = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Environment SRAM: combinational read, byte-enabled write.
  assign sram_rdata = mem[sram_addr[7:0]];
  always @(posedge clk) begin
    if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_wen[b]) mem[sram_addr[7:0]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One bus cycle: drive, predict from the arbitration rules, check the SRAM side.
  task automatic bus_cycle(input bit rst, input bit ir, input logic [31:0] ia,
                           input bit dr, input bit dw, input logic [3:0] ds,
                           input logic [31:0] da, input logic [31:0] dd,
                           output bit gi, output bit gd);
    logic [31:0] word;
    resp_t e;
    reset = rst; inst_req = ir; inst_addr = ia;
    data_req = dr; data_wr = dw; data_wstrb = ds; data_addr = da; data_wdata = dd;
    @(negedge clk);
    gi = 1'b0; gd = 1'b0;
    if (!rst) begin
      if (ir && dr) begin
`ifdef SRAM_ARB_RR_EN
        gd = !m_last_data;
        gi = m_last_data;
`else
        gd = 1'b1;
`endif
      end else begin
        gi = ir;
        gd = dr;
      end
    end
    if (rst) m_last_data = 1'b0;
    else if (gi) m_last_data = 1'b0;
    else if (gd) m_last_data = 1'b1;

    chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, gi});
    chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, gd});
    chk("sram_en", {31'd0, sram_en}, {31'd0, gi | gd});
    chk("sram_wen", {28'd0, sram_wen}, (gd && dw) ? {28'd0, ds} : 32'd0);
    chk("sram_addr", sram_addr, gd ? (da >> 2) : (gi ? (ia >> 2) : 32'd0));
    chk("sram_wdata", sram_wdata, gd ? dd : 32'd0);

    if (gi || gd) begin
      word = m_mem[gd ? da[9:2] : ia[9:2]];
      e.is_data = gd; e.is_store = gd && dw; e.rdata = word; e.due = cyc + 1;
      exp_q.push_back(e);
      if (gd && dw)
        for (int b = 0; b < 4; b++)
          if (ds[b]) m_mem[da[9:2]][b*8 +: 8] = dd[b*8 +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the response due this cycle and checks hold behaviour otherwise.
  logic [31:0] last_i = 32'd0, last_d = 32'd0;
  bit          last_d_valid = 1'b1;
  bit          mon_en = 1'b0;
  always @(negedge clk) begin
    resp_t e;
    bit exp_i, exp_d;
    if (mon_en) begin
      if (reset) begin
        chk("inst_data_ok_rst", {31'd0, inst_data_ok}, 32'd0);
        chk("data_data_ok_rst", {31'd0, data_data_ok}, 32'd0);
        chk("inst_rdata_rst", inst_rdata, 32'd0);
        chk("data_rdata_rst", data_rdata, 32'd0);
        exp_q.delete();
        last_i = 32'd0; last_d = 32'd0; last_d_valid = 1'b1;
      end else begin
        exp_i = 1'b0; exp_d = 1'b0;
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          e = exp_q.pop_front();
          chk("stale_response", e.due, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          exp_i = !e.is_data;
          exp_d = e.is_data;
        end
        chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, exp_i});
        chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, exp_d});
        if (exp_i) begin
          chk("inst_rdata", inst_rdata, e.rdata);
          last_i = e.rdata;
        end else begin
          chk("inst_rdata_hold", inst_rdata, last_i);
        end
        if (exp_d) begin
          if (!e.is_store) chk("data_rdata", data_rdata, e.rdata);
          last_d = e.rdata;
          last_d_valid = !e.is_store;
        end else if (last_d_valid) begin
          chk("data_rdata_hold", data_rdata, last_d);
        end
      end
    end
  end

  initial begin
    bit gi, gd, ir, dr, dw, rst;
    logic [31:0] ia, da, dd;
    logic [3:0] ds;
    int data_grants;

    for (int i = 0; i < 256; i++) begin
      mem[i]   = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
      m_mem[i] = (i * 32'h0101_0101) ^ 32'h5A5A_0000;
    end
    mem[8]   = 32'hDEAD_BEEF;
    m_mem[8] = 32'hDEAD_BEEF;
    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    inst_addr = 32'd0; data_addr = 32'd0; data_wdata = 32'd0; data_wstrb = 4'd0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    repeat (2) bus_cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);

    // Lone fetch, then store/load round trip through word 8.
    bus_cycle(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    bus_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h0000_0020, 32'hAABB_CCDD, gi, gd);
    bus_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'b0000, 32'h0000_0020, 32'd0, gi, gd);
    bus_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    chk("store_merge_model", m_mem[8], 32'hDEAD_CCDD);

    // Both requesters held for four cycles.
    data_grants = 0;
    for (int k = 0; k < 4; k++) begin
      bus_cycle(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 4'd0, 32'h0000_0044, 32'd0, gi, gd);
      if (gd) data_grants++;
    end
`ifdef SRAM_ARB_RR_EN
    chk("conflict_data_grants", data_grants, 32'd2);
`else
    chk("conflict_data_grants", data_grants, 32'd4);
`endif

    // Reset right after an acceptance, then a conflict.
    bus_cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'h0000_0030, 32'd0, gi, gd);
    bus_cycle(1'b1, 1'b1, 32'h0000_0050, 1'b1, 1'b0, 4'd0, 32'h0000_0030, 32'd0, gi, gd);
    bus_cycle(1'b0, 1'b1, 32'h0000_0050, 1'b1, 1'b0, 4'd0, 32'h0000_0034, 32'd0, gi, gd);
    chk("post_reset_conflict_data", {31'd0, data_addr_ok}, 32'd1);

    repeat (10) bus_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);

    // Random traffic; an ungranted request is held unchanged.
    ir = 1'b0; dr = 1'b0; gi = 1'b0; gd = 1'b0;
    ia = 32'd0; da = 32'd0; dd = 32'd0; ds = 4'd0; dw = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!(ir && !gi)) begin
        ir = ($urandom_range(0, 99) < 60);
        ia = $urandom_range(0, 1023);
      end
      if (!(dr && !gd)) begin
        dr = ($urandom_range(0, 99) < 60);
        dw = $urandom_range(0, 1);
        ds = $urandom_range(0, 15);
        da = $urandom_range(0, 1023);
        dd = $urandom;
      end
      rst = ($urandom_range(0, 59) == 0);
      bus_cycle(rst, ir, ia, dr, dw, ds, da, dd, gi, gd);
    end

    repeat (2) bus_cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, gi, gd);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
